// File: rtl/panel_pkg.sv
// Shared types and defaults for the panel image sequencer.
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BLANK = 2'd2
  } seq_state_t;

  localparam logic DIR_NEXT = 1'b0;
  localparam logic DIR_PREV = 1'b1;

  localparam int DEF_NUM_IMAGES = 4;
  localparam int DEF_SEL_W      = 2;

endpackage

// File: rtl/image_sequencer_if.sv
// Button/frame/control bundle between the panel front end and the image sequencer.
interface image_sequencer_if #(
  parameter int SEL_W = panel_pkg::DEF_SEL_W
);
  logic             next_pulse;
  logic             prev_pulse;
  logic             frame_end;
  logic             auto_en;
  logic [SEL_W-1:0] image_sel;
  logic             blank;
  logic             busy;
  logic             switch_done;
  logic             dropped;

  modport master (
    output next_pulse, prev_pulse, frame_end, auto_en,
    input  image_sel, blank, busy, switch_done, dropped
  );

  modport slave (
    input  next_pulse, prev_pulse, frame_end, auto_en,
    output image_sel, blank, busy, switch_done, dropped
  );
endinterface

// File: rtl/frame_tick_timer.sv
// Counts frame_end strobes while enabled; emits a one-cycle tick every FRAMES frames.
module frame_tick_timer #(
  parameter int FRAMES = 600
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_frame_end,
  output logic o_tick
);
  localparam int CW = $clog2(FRAMES + 1);

  logic [CW-1:0] r_cnt;
  logic          w_hit;

  // A clear in the same cycle as the terminal frame suppresses the tick.
  assign w_hit  = i_en & i_frame_end & ~i_clr & (r_cnt == CW'(FRAMES - 1));
  assign o_tick = w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_cnt <= '0;
    else if (i_clr || w_hit)   r_cnt <= '0;
    else if (i_en && i_frame_end) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/image_sequencer.sv
// Frame-synchronous image-select scheduler with optional blanking frames.
// Optional auto-advance source built only when IMAGE_SEQ_AUTO_CYCLE_EN is defined.
module image_sequencer
  import panel_pkg::*;
#(
  parameter int NUM_IMAGES   = DEF_NUM_IMAGES,
  parameter int SEL_W        = DEF_SEL_W,
  parameter int BLANK_FRAMES = 1,
  parameter int AUTO_FRAMES  = 600
) (
  input logic               clk,
  input logic               rst,
  image_sequencer_if.slave  bus
);
  localparam int BCW = $clog2(BLANK_FRAMES + 2);

  seq_state_t       r_state, w_next;
  logic             r_dir, r_done, r_dropped;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [BCW-1:0]   r_bcnt;
  logic             w_man_req, w_auto_tick, w_req, w_dir;
  logic             w_latch, w_commit, w_finish, w_drop, w_bdec;
  logic [SEL_W:0]   w_inc, w_dec;

  // Both buttons at once cancel out; auto tick only fills otherwise idle cycles.
  assign w_man_req = bus.next_pulse ^ bus.prev_pulse;
  assign w_req     = w_man_req | (w_auto_tick & ~bus.next_pulse & ~bus.prev_pulse);
  assign w_dir     = (w_man_req && bus.prev_pulse) ? DIR_PREV : DIR_NEXT;

`ifdef IMAGE_SEQ_AUTO_CYCLE_EN
  frame_tick_timer #(.FRAMES(AUTO_FRAMES)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_en        (bus.auto_en && (r_state == IDLE)),
    .i_clr       (w_man_req || !bus.auto_en),
    .i_frame_end (bus.frame_end),
    .o_tick      (w_auto_tick)
  );
`else
  logic w_unused_auto;
  assign w_unused_auto = bus.auto_en;
  assign w_auto_tick   = 1'b0;
`endif

  assign w_inc = {1'b0, r_sel} + (SEL_W+1)'(1);
  assign w_dec = {1'b0, r_sel} - (SEL_W+1)'(1);
  assign w_sel_nxt = (r_dir == DIR_NEXT)
                   ? ((w_inc == (SEL_W+1)'(NUM_IMAGES)) ? '0 : w_inc[SEL_W-1:0])
                   : (w_dec[SEL_W] ? SEL_W'(NUM_IMAGES - 1) : w_dec[SEL_W-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_commit = 1'b0;
    w_finish = 1'b0;
    w_drop   = 1'b0;
    w_bdec   = 1'b0;
    case (r_state)
      IDLE: if (w_req) begin
        w_next  = ARMED;
        w_latch = 1'b1;
      end
      ARMED: begin
        w_drop = w_req;
        if (bus.frame_end) begin
          w_commit = 1'b1;
          if (BLANK_FRAMES == 0) begin
            w_next   = IDLE;
            w_finish = 1'b1;
          end else begin
            w_next = BLANK;
          end
        end
      end
      BLANK: begin
        w_drop = w_req;
        if (bus.frame_end) begin
          if (r_bcnt == BCW'(1)) begin
            w_next   = IDLE;
            w_finish = 1'b1;
          end else begin
            w_bdec = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir     <= DIR_NEXT;
      r_sel     <= '0;
      r_bcnt    <= '0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      if (w_latch)  r_dir <= w_dir;
      if (w_commit) r_sel <= w_sel_nxt;
      if (w_commit)    r_bcnt <= BCW'(BLANK_FRAMES);
      else if (w_bdec) r_bcnt <= r_bcnt - BCW'(1);
      r_done <= w_finish;
      if (w_drop) r_dropped <= 1'b1;
    end
  end

  assign bus.image_sel   = r_sel;
  assign bus.blank       = (r_state == BLANK);
  assign bus.busy        = (r_state != IDLE);
  assign bus.switch_done = r_done;
  assign bus.dropped     = r_dropped;
endmodule

// File: doc/image_sequencer.md
Name: image_sequencer

Overview:
Frame-synchronous scheduler that owns the image-select index feeding panel memory. It arbitrates between the debounced next/prev button pulses and an optional auto-advance timer. Image changes are committed only at a frame boundary, with optional blanking frames, so the panel never shows a torn frame. It sits between the button debouncers, the scan-counter frame strobe, the memory image_sel input and the output-enable path.

Parameters:
NUM_IMAGES, 4, number of stored images; index wraps modulo NUM_IMAGES (2..2^SEL_W)
SEL_W, 2, width of image_sel
BLANK_FRAMES, 1, whole frames held blank around a switch (0 = switch with no blanking)
AUTO_FRAMES, 600, frames between auto-advance requests (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
next_pulse  in  1  one-cycle request to advance by +1
prev_pulse  in  1  one-cycle request to step back by -1
frame_end  in  1  one-cycle strobe on the last cycle of a full frame (all rows and PWM planes)
auto_en  in  1  enables the auto-advance source (level)
image_sel  out  SEL_W  current image index to memory
blank  out  1  high = force the panel dark (ORed into oe)
busy  out  1  high while a request is pending or blanking
switch_done  out  1  one-cycle pulse when the sequence returns to IDLE
dropped  out  1  sticky flag: a request arrived while busy; cleared only by reset

Behaviour:
- Reset (rst=0, async): image_sel=0, blank=0, busy=0, switch_done=0, dropped=0, state=IDLE, auto counter=0, blank counter=0.
- States: IDLE, ARMED, BLANK.
- Request decode per cycle: prev_pulse&next_pulse together = no request. Otherwise prev gives dir=-1 and next gives dir=+1. An auto tick gives dir=+1 only when neither button is active in that cycle. A manual request beats an auto tick in the same cycle.
- IDLE + request: latch dir, go to ARMED next cycle, busy=1.
- IDLE + request + frame_end in the same cycle: still go to ARMED. The commit waits for the next frame_end.
- ARMED + frame_end:
  - BLANK_FRAMES>0: on that edge, update image_sel, set blank=1, load the blank counter, go to BLANK.
  - BLANK_FRAMES=0: on that edge, update image_sel, pulse switch_done next cycle, return to IDLE with busy=0.
- BLANK: decrement the counter on each frame_end. On the frame_end where counter=1: clear blank, clear busy, pulse switch_done, go to IDLE. Blank therefore covers exactly BLANK_FRAMES full frames.
- Index arithmetic: +1 from NUM_IMAGES-1 wraps to 0. -1 from 0 wraps to NUM_IMAGES-1. Computed in SEL_W+1 bits, no modulo operator.
- Requests arriving in ARMED or BLANK are discarded and set dropped=1. No queueing.
- image_sel changes only on a frame_end edge. It never changes mid-frame.
- Asserting reset mid-sequence aborts it at once: blank drops, image_sel returns to 0.

Optional Feature:
IMAGE_SEQ_AUTO_CYCLE_EN.
- Defined: the auto counter increments on each frame_end while auto_en=1 and state=IDLE.
  - On reaching AUTO_FRAMES-1 together with a frame_end, it raises a one-cycle auto tick and clears.
  - Any manual request, or auto_en=0, clears the counter.
- Undefined: the counter and tick logic are not built, the tick is constant 0, auto_en is ignored, and the port list is unchanged.

Decomposition:
- Shared package panel_pkg:
  - seq_state_t enum (IDLE, ARMED, BLANK).
  - dir encoding constants (DIR_NEXT, DIR_PREV).
  - Default NUM_IMAGES and SEL_W.
- One natural sub-module: frame_tick_timer. It is a parameterised frame_end counter that produces the auto tick and is instantiated only under IMAGE_SEQ_AUTO_CYCLE_EN.

Test Plan:
1. Reset, then next_pulse at cycle 10 and frame_end at cycle 50 (BLANK_FRAMES=1) -> busy=1 from cycle 11; image_sel 0->1 and blank=1 at 51; blank=0, switch_done pulse at the next frame_end +1.
2. image_sel=0, prev_pulse, two frame_ends -> image_sel=3. From 3, next_pulse -> image_sel=0 (wrap both ways).
3. next_pulse and prev_pulse in the same cycle -> no state change, busy stays 0, dropped stays 0.
4. next_pulse, then prev_pulse while ARMED -> single +1 applied, dropped=1, and it stays 1 until reset.
5. With IMAGE_SEQ_AUTO_CYCLE_EN, AUTO_FRAMES=3, auto_en=1, 8 frame_ends -> exactly two auto advances. A next_pulse at frame 2 restarts the count. With the macro undefined -> image_sel constant.
6. Drive rst low while in BLANK -> blank=0, image_sel=0, busy=0 immediately, without waiting for a clock edge.
